// File: rtl/mem_arbiter.sv
// mem_arbiter: two-requester valid/ready arbiter sequencing one access at a time
// into a 16x16 synchronous memory, with a one-cycle response pulse per command.
module mem_arbiter #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 16,
    parameter int RR_EN  = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rsp_valid,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rsp_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_ip,
    output logic              mem_we,
    output logic              mem_oe,
    input  logic [DATA_W-1:0] mem_op
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    state_t state;
    logic last_grant, owner, cmd_we, grant_b;
    // last_grant/owner: 0 = A, 1 = B; mem_addr/mem_ip double as the command address/data regs
    assign grant_b = b_valid & (~a_valid | ((RR_EN != 0) & ~last_grant));
    assign a_ready = rst_n & (state == IDLE) & a_valid & ~grant_b;
    assign b_ready = rst_n & (state == IDLE) & grant_b;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            cmd_we      <= 1'b0;
            rsp_rdata   <= '0;
            mem_addr    <= '0;
            mem_ip      <= '0;
            mem_we      <= 1'b0;
            mem_oe      <= 1'b0;
            a_rsp_valid <= 1'b0;
            b_rsp_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: if (a_ready | b_ready) begin
                    owner      <= grant_b;
                    last_grant <= grant_b;
                    cmd_we     <= grant_b ? b_we : a_we;
                    mem_addr   <= grant_b ? b_addr : a_addr;
                    mem_ip     <= grant_b ? b_wdata : a_wdata;
                    mem_we     <= grant_b ? b_we : a_we;
                    mem_oe     <= grant_b ? ~b_we : ~a_we;
                    state      <= ACCESS;
                end
                ACCESS: begin
                    if (!cmd_we) rsp_rdata <= mem_op;
                    mem_we      <= 1'b0;
                    mem_oe      <= 1'b0;
                    a_rsp_valid <= ~owner;
                    b_rsp_valid <= owner;
                    state       <= RESP;
                end
                default: begin
                    a_rsp_valid <= 1'b0;
                    b_rsp_valid <= 1'b0;
                    state       <= IDLE;
                end
            endcase
        end
    end
endmodule
